// File: rtl/branch_req_scheduler.sv
// rtl/branch_req_scheduler.sv - event FIFO and handshake sequencer in front of the perceptron predictor
module branch_req_scheduler #(
    parameter int ADDR_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 127
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic                          in_taken,
    input  logic                          mem_reset_done,
    input  logic                          pred_ready,
    input  logic                          prediction,
    input  logic                          training_done,
    output logic [ADDR_WIDTH-1:0]         bp_addr,
    output logic                          bp_taken,
    output logic                          bp_new_data,
    output logic                          out_valid,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic                          out_prediction,
    output logic                          out_mispredict,
    output logic                          busy,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [7:0]       WD_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_WAIT_MEM,
        S_IDLE,
        S_ISSUE,
        S_WAIT_PRED,
        S_WAIT_TRAIN,
        S_GAP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_WIDTH-1:0]  r_mem_addr [FIFO_DEPTH];
    logic                   r_mem_taken [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_next;
    logic                   r_in_ready;
    logic [7:0]             r_wd;
    logic [ADDR_WIDTH-1:0]  r_bp_addr;
    logic                   r_bp_taken;
    logic                   r_bp_new_data;
    logic                   r_out_valid;
    logic [ADDR_WIDTH-1:0]  r_out_addr;
    logic                   r_out_prediction;
    logic                   r_out_mispredict;
    logic                   r_timeout_err;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_load;
    logic                   w_emit;
    logic                   w_timeout;
    logic                   w_wd_expired;
    logic                   w_wd_run;

    assign w_push       = in_valid & r_in_ready;
    assign w_wd_expired = (r_wd >= WD_LIMIT);
    assign w_wd_run     = (r_state == S_ISSUE) || (r_state == S_WAIT_PRED) || (r_state == S_WAIT_TRAIN);

    // The watchdog doubles as the ISSUE phase timer: it reads 0 then 1 across the two ISSUE cycles.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_load    = 1'b0;
        w_emit    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_WAIT_MEM: begin
                if (mem_reset_done) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (r_count != '0) begin
                    w_next = S_ISSUE;
                    w_load = 1'b1;
                end
            end
            S_ISSUE: begin
                if (r_wd == 8'd1) w_next = S_WAIT_PRED;
            end
            S_WAIT_PRED: begin
                if (pred_ready) begin
                    w_emit = 1'b1;
                    if (training_done) begin
                        w_pop  = 1'b1;
                        w_next = S_GAP;
                    end else begin
                        w_next = S_WAIT_TRAIN;
                    end
                end else if (w_wd_expired) begin
                    w_timeout = 1'b1;
                    w_pop     = 1'b1;
                    w_next    = S_GAP;
                end
            end
            S_WAIT_TRAIN: begin
                if (training_done) begin
                    w_pop  = 1'b1;
                    w_next = S_GAP;
                end else if (w_wd_expired) begin
                    w_timeout = 1'b1;
                    w_pop     = 1'b1;
                    w_next    = S_GAP;
                end
            end
            S_GAP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_WAIT_MEM;
            end
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr]  <= in_addr;
            r_mem_taken[r_wr_ptr] <= in_taken;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_WAIT_MEM;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_in_ready       <= 1'b1;
            r_wd             <= '0;
            r_bp_addr        <= '0;
            r_bp_taken       <= 1'b0;
            r_bp_new_data    <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_addr       <= '0;
            r_out_prediction <= 1'b0;
            r_out_mispredict <= 1'b0;
            r_timeout_err    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_count       <= w_count_next;
            r_in_ready    <= (w_count_next < CNT_FULL);
            r_bp_new_data <= (w_next == S_ISSUE);
            r_out_valid   <= w_emit;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_timeout) r_timeout_err <= 1'b1;
            if (w_load) begin
                r_wd       <= '0;
                r_bp_addr  <= r_mem_addr[r_rd_ptr];
                r_bp_taken <= r_mem_taken[r_rd_ptr];
            end else if (w_wd_run && (r_wd != 8'hFF)) begin
                r_wd <= r_wd + 8'd1;
            end
            if (w_emit) begin
                r_out_addr       <= r_bp_addr;
                r_out_prediction <= prediction;
                r_out_mispredict <= prediction ^ r_bp_taken;
            end
        end
    end

    assign in_ready       = r_in_ready;
    assign fifo_count     = r_count;
    assign bp_addr        = r_bp_addr;
    assign bp_taken       = r_bp_taken;
    assign bp_new_data    = r_bp_new_data;
    assign out_valid      = r_out_valid;
    assign out_addr       = r_out_addr;
    assign out_prediction = r_out_prediction;
    assign out_mispredict = r_out_mispredict;
    assign timeout_err    = r_timeout_err;
    assign busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_branch_req_scheduler.sv
// tb/tb_branch_req_scheduler.sv - randomized, model-checked bench for branch_req_scheduler
module tb_branch_req_scheduler;
    localparam int AW = 8;
    localparam int D  = 4;
    localparam int TO = 127;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [AW-1:0]      in_addr = '0;
    logic               in_taken = 1'b0;
    logic               mem_reset_done = 1'b0;
    logic               pred_ready = 1'b0;
    logic               prediction = 1'b0;
    logic               training_done = 1'b0;
    logic [AW-1:0]      bp_addr;
    logic               bp_taken;
    logic               bp_new_data;
    logic               out_valid;
    logic [AW-1:0]      out_addr;
    logic               out_prediction;
    logic               out_mispredict;
    logic               busy;
    logic               timeout_err;
    logic [$clog2(D):0] fifo_count;

    always #5 clk = ~clk;

    branch_req_scheduler #(.ADDR_WIDTH(AW), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_taken(in_taken), .mem_reset_done(mem_reset_done),
        .pred_ready(pred_ready), .prediction(prediction), .training_done(training_done),
        .bp_addr(bp_addr), .bp_taken(bp_taken), .bp_new_data(bp_new_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_prediction(out_prediction),
        .out_mispredict(out_mispredict), .busy(busy), .timeout_err(timeout_err),
        .fifo_count(fifo_count)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          taken;
    } ent_t;

    // Transaction-level model: a queue of pending events plus the age of the one in flight.
    ent_t          m_q[$];
    bit            m_mem_ok, m_active, m_got_pred, m_gap, m_in_ready;
    bit            m_tout_err, m_out_valid, m_out_pred, m_out_mis, m_bp_taken;
    logic [AW-1:0] m_bp_addr, m_out_addr;
    int            m_age;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            plan_sel = 0;
    int            pred_age, train_age;
    logic          plan_val;
    bit            spurious = 0;
    bit            prev_nd = 0;
    logic [AW-1:0] issued[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_mem_ok = 0; m_active = 0; m_got_pred = 0; m_gap = 0; m_in_ready = 1;
        m_tout_err = 0; m_out_valid = 0; m_out_pred = 0; m_out_mis = 0;
        m_bp_taken = 0; m_bp_addr = '0; m_out_addr = '0; m_age = 0;
    endtask

    task automatic choose_plan();
        int mode;
        int r;
        mode = plan_sel;
        if (mode == 5) begin
            r = int'($urandom_range(0, 39));
            mode = (r == 0) ? 3 : ((r == 1) ? 4 : 0);
        end
        plan_val = 1'($urandom);
        case (mode)
            1: begin pred_age = 2;  train_age = 2;      plan_val = 1'b1; end
            2: begin pred_age = 2;  train_age = 36;     plan_val = 1'b1; end
            3: begin pred_age = -1; train_age = -1;                      end
            4: begin pred_age = TO; train_age = TO + 3;                  end
            default: begin
                pred_age  = 2 + int'($urandom_range(0, 5));
                train_age = pred_age + int'($urandom_range(0, 4));
            end
        endcase
        if (plan_sel >= 1 && plan_sel <= 4) plan_sel = 0;
    endtask

    task automatic model_step();
        bit   push, pop, emit, tout, start;
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        push = in_valid && m_in_ready;
        pop = 0; emit = 0; tout = 0; start = 0;
        if (!m_mem_ok) begin
            if (mem_reset_done) m_mem_ok = 1;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (!m_active) begin
            start = (m_q.size() > 0);
        end else if (m_age >= 2) begin
            if (!m_got_pred && pred_ready) begin
                emit = 1;
                if (training_done) pop = 1;
                else m_got_pred = 1;
            end else if (m_got_pred && training_done) begin
                pop = 1;
            end else if (m_age >= TO) begin
                tout = 1;
                pop = 1;
            end
        end
        m_out_valid = emit;
        if (emit) begin
            m_out_addr = m_bp_addr;
            m_out_pred = prediction;
            m_out_mis  = prediction ^ m_bp_taken;
        end
        if (tout) m_tout_err = 1;
        if (pop) begin
            m_q.delete(0);
            m_active = 0;
            m_gap = 1;
        end else if (start) begin
            m_active = 1; m_age = 0; m_got_pred = 0;
            m_bp_addr = m_q[0].addr;
            m_bp_taken = m_q[0].taken;
            choose_plan();
        end else if (m_active && m_age < 255) begin
            m_age++;
        end
        if (push) begin
            e.addr = in_addr;
            e.taken = in_taken;
            m_q.push_back(e);
        end
        m_in_ready = (m_q.size() < D);
    endtask

    task automatic compare();
        chk("in_ready", 32'(in_ready), 32'(m_in_ready));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("bp_new_data", 32'(bp_new_data), 32'(m_active && m_age < 2));
        chk("bp_addr", 32'(bp_addr), 32'(m_bp_addr));
        chk("bp_taken", 32'(bp_taken), 32'(m_bp_taken));
        chk("out_valid", 32'(out_valid), 32'(m_out_valid));
        chk("out_addr", 32'(out_addr), 32'(m_out_addr));
        chk("out_prediction", 32'(out_prediction), 32'(m_out_pred));
        chk("out_mispredict", 32'(out_mispredict), 32'(m_out_mis));
        chk("busy", 32'(busy), 32'(!(m_mem_ok && !m_active && !m_gap)));
        chk("timeout_err", 32'(timeout_err), 32'(m_tout_err));
    endtask

    task automatic drive_predictor();
        pred_ready = 1'b0;
        training_done = 1'b0;
        prediction = 1'($urandom);
        if (m_active && m_age >= 2) begin
            if (!m_got_pred && m_age == pred_age) begin
                pred_ready = 1'b1;
                prediction = plan_val;
            end
            if (m_age == train_age && (m_got_pred || m_age == pred_age)) training_done = 1'b1;
        end else if (spurious && !m_active) begin
            pred_ready = ($urandom_range(0, 3) == 0);
            training_done = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare();
        if (bp_new_data === 1'b1 && !prev_nd) issued.push_back(bp_addr);
        prev_nd = (bp_new_data === 1'b1);
        drive_predictor();
    endtask

    task automatic push_one(input logic [AW-1:0] a, input logic t);
        in_valid = 1'b1; in_addr = a; in_taken = t;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int bound);
        bit done;
        done = 0;
        for (int i = 0; i < bound; i++) begin
            if (m_mem_ok && !m_active && !m_gap && m_q.size() == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        chk("idle_wait", 32'(done), 32'd1);
    endtask

    task automatic pulse_mem();
        mem_reset_done = 1'b1;
        tick();
        mem_reset_done = 1'b0;
    endtask

    initial begin
        int nd_cnt, ov_cnt, t_issue, t_to;
        bit ok;
        logic [AW-1:0] exp_order[6];

        model_reset();
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        chk("rst_bp_new_data", 32'(bp_new_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;

        // Block must stay parked until the predictor finishes its memory clear.
        spurious = 1;
        repeat (20) tick();
        spurious = 0;
        push_one(8'h14, 1'b1);
        chk("wm_fifo_count", 32'(fifo_count), 32'd1);
        repeat (3) tick();
        chk("wm_bp_new_data", 32'(bp_new_data), 32'd0);
        chk("wm_busy", 32'(busy), 32'd1);

        plan_sel = 1;
        pulse_mem();
        nd_cnt = 0; ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bp_new_data === 1'b1) begin
                nd_cnt++;
                chk("first_bp_addr", 32'(bp_addr), 32'h14);
                chk("first_bp_taken", 32'(bp_taken), 32'd1);
            end
            if (out_valid === 1'b1) begin
                ov_cnt++;
                chk("first_out_prediction", 32'(out_prediction), 32'd1);
                chk("first_out_mispredict", 32'(out_mispredict), 32'd0);
                chk("first_out_addr", 32'(out_addr), 32'h14);
            end
        end
        chk("first_nd_cycles", 32'(nd_cnt), 32'd2);
        chk("first_out_pulses", 32'(ov_cnt), 32'd1);
        chk("first_idle_busy", 32'(busy), 32'd0);
        chk("first_empty", 32'(fifo_count), 32'd0);

        plan_sel = 2;
        push_one(8'h33, 1'b0);
        ov_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                ov_cnt++;
                chk("misp_flag", 32'(out_mispredict), 32'd1);
                chk("misp_pred", 32'(out_prediction), 32'd1);
                chk("misp_count_held", 32'(fifo_count), 32'd1);
            end
        end
        chk("misp_pulses", 32'(ov_cnt), 32'd1);
        chk("misp_empty", 32'(fifo_count), 32'd0);

        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_addr = 8'hA0 + 8'(i); in_taken = 1'(i);
            tick();
            if (i == 3) begin
                chk("full_in_ready", 32'(in_ready), 32'd0);
                chk("full_count", 32'(fifo_count), 32'd4);
            end
        end
        in_valid = 1'b0;
        chk("drop_count", 32'(fifo_count), 32'd4);
        issued.delete();
        plan_sel = 0;
        pulse_mem();
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_q.size() == 2) begin ok = 1; break; end
            tick();
        end
        chk("two_pops_wait", 32'(ok), 32'd1);
        push_one(8'hA5, 1'b1);
        push_one(8'hA6, 1'b0);
        run_until_idle(400);
        exp_order = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA5, 8'hA6};
        chk("order_len", 32'(issued.size()), 32'd6);
        for (int i = 0; i < 6 && i < issued.size(); i++) chk("order_addr", 32'(issued[i]), 32'(exp_order[i]));

        issued.delete();
        plan_sel = 3;
        push_one(8'h5A, 1'b1);
        push_one(8'h6B, 1'b0);
        ov_cnt = 0; t_issue = -1; t_to = -1;
        for (int i = 0; i < 400; i++) begin
            if (issued.size() >= 1 && t_issue < 0) t_issue = cyc;
            if (timeout_err === 1'b1 && t_to < 0) t_to = cyc;
            if (out_valid === 1'b1) ov_cnt++;
            if (m_mem_ok && !m_active && !m_gap && m_q.size() == 0) break;
            tick();
        end
        chk("to_flag", 32'(timeout_err), 32'd1);
        chk("to_latency", 32'(t_to - t_issue), 32'd128);
        chk("to_pulses", 32'(ov_cnt), 32'd1);
        chk("to_issued", 32'(issued.size()), 32'd2);
        if (issued.size() == 2) chk("to_next_addr", 32'(issued[1]), 32'h6B);

        plan_sel = 4;
        push_one(8'h77, 1'b1);
        ov_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (out_valid === 1'b1) ov_cnt++;
            if (m_mem_ok && !m_active && !m_gap && m_q.size() == 0) break;
        end
        chk("late_pred_pulses", 32'(ov_cnt), 32'd1);

        plan_sel = 5;
        spurious = 1;
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_addr = 8'($urandom);
            in_taken = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        spurious = 0;
        plan_sel = 0;
        run_until_idle(600);

        // Reset mid-training with a full queue behind the in-flight entry.
        plan_sel = 2;
        for (int i = 0; i < 4; i++) push_one(8'hC0 + 8'(i), 1'b1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_active && m_got_pred) begin ok = 1; break; end
            tick();
        end
        chk("train_wait", 32'(ok), 32'd1);
        chk("pre_rst_count", 32'(fifo_count), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd1);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_fifo_count", 32'(fifo_count), 32'd0);
        chk("arst_bp_addr", 32'(bp_addr), 32'd0);
        chk("arst_bp_taken", 32'(bp_taken), 32'd0);
        chk("arst_bp_new_data", 32'(bp_new_data), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_addr", 32'(out_addr), 32'd0);
        chk("arst_out_prediction", 32'(out_prediction), 32'd0);
        chk("arst_out_mispredict", 32'(out_mispredict), 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("post_rst_busy", 32'(busy), 32'd1);
        issued.delete();
        push_one(8'hD1, 1'b0);
        chk("post_rst_no_issue", 32'(bp_new_data), 32'd0);
        pulse_mem();
        run_until_idle(100);
        chk("post_rst_issued", 32'(issued.size()), 32'd1);
        if (issued.size() == 1) chk("post_rst_addr", 32'(issued[0]), 32'hD1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_req_scheduler.md
# branch_req_scheduler

- Sequences branch events into the perceptron predictor, one at a time.
- Sits between the external branch-event source and the predictor core.
- Buffers incoming events (instruction address plus resolved direction) in a small FIFO and holds off issue until the predictor's memory clear completes.
- Drives the predictor's level/edge-triggered handshake, collects each prediction, flags mispredicts, and retires an entry once training completes or a watchdog expires.

## Interface
- ADDR_WIDTH, 8, width of instruction address passed to predictor
- FIFO_DEPTH, 4, event buffer entries; power of 2, ≥2
- TIMEOUT_CYCLES, 127, max cycles from issue to retire before abort; fits in 8 bits
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  event push request
- in_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
- in_addr  in  ADDR_WIDTH  branch instruction address
- in_taken  in  1  resolved branch direction
- mem_reset_done  in  1  predictor memory-clear complete, 1-cycle pulse
- pred_ready  in  1  predictor result valid, 1-cycle pulse
- prediction  in  1  predictor output, valid with pred_ready
- training_done  in  1  predictor finished with entry, 1-cycle pulse
- bp_addr  out  ADDR_WIDTH  to predictor inst_addr
- bp_taken  out  1  to predictor ground-truth input
- bp_new_data  out  1  to predictor new-data input
- out_valid  out  1  result pulse
- out_addr  out  ADDR_WIDTH  address of resolved entry
- out_prediction  out  1  predicted direction
- out_mispredict  out  1  prediction != bp_taken
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
States and transitions:
- WAIT_MEM: entered on reset. Exits to IDLE on mem_reset_done. Pushes are accepted in this state.
- IDLE: if fifo_count>0, go to ISSUE. On entry to ISSUE, load bp_addr/bp_taken from the FIFO head and set bp_new_data=1.
- ISSUE: lasts exactly 2 cycles with bp_new_data=1, then goes to WAIT_PRED with bp_new_data=0.
- WAIT_PRED: on pred_ready, emit an out_valid pulse with out_prediction=prediction, out_addr=bp_addr, out_mispredict=prediction^bp_taken.
  - If training_done is in the same cycle, pop the head and go to GAP.
  - Otherwise go to WAIT_TRAIN.
- WAIT_TRAIN: on training_done, pop the head and go to GAP.
- GAP: 1 cycle, then IDLE.

Signal rules:
- bp_addr/bp_taken change only on entry to ISSUE. They are held stable through WAIT_PRED, WAIT_TRAIN and GAP, because the predictor reads them during training.

Watchdog:
- An 8-bit counter clears on entry to ISSUE and increments in ISSUE, WAIT_PRED and WAIT_TRAIN.
- When it reaches TIMEOUT_CYCLES:
  - set timeout_err (stays set until reset)
  - pop the head
  - go to GAP
  - no out_valid pulse
- A pred_ready or training_done in the timeout cycle takes priority over the timeout.
- pred_ready/training_done are ignored in IDLE, GAP and WAIT_MEM.

FIFO:
- Push when in_valid&in_ready at the clock edge. Data is stored; the write pointer wraps modulo FIFO_DEPTH.
- Pop only on retire; the read pointer wraps modulo FIFO_DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- in_ready is registered from the next count. When full, in_valid is ignored with no side effects.
- A pop in the same cycle as a full-state push attempt does not accept that push.

## Timing
Reset values:
- state=WAIT_MEM, busy=1, in_ready=1, fifo_count=0, timeout_err=0
- bp_addr=0, bp_taken=0, bp_new_data=0
- out_valid=0, out_addr=0, out_prediction=0, out_mispredict=0

Reset behaviour:
- rst_n low at any time aborts the in-flight entry and empties the FIFO.
- After reset the block waits for a fresh mem_reset_done.

Outputs:
- All outputs are registered except busy, which is decoded from the state register.

Latency:
- Push captured at edge E0: fifo_count=1 after E0.
- With the block in IDLE, bp_new_data rises after E1 and falls after E3.
- out_valid asserts in the cycle after the edge sampling pred_ready.

Issue spacing:
- bp_new_data is low for at least 3 cycles between consecutive issues (WAIT_PRED≥1, GAP, IDLE).

## Test plan
- Reset, then 20 idle cycles without mem_reset_done, then push addr=0x14 taken=1 -> bp_new_data stays 0 and fifo_count=1. After a mem_reset_done pulse, bp_new_data is high for exactly 2 cycles with bp_addr=0x14, bp_taken=1.
- Predictor model returns pred_ready with prediction=1 and training_done in the same cycle -> out_valid=1, out_prediction=1, out_mispredict=0. Entry popped, GAP, then IDLE.
- Entry taken=0, predictor returns prediction=1, training_done 34 cycles later -> out_mispredict=1. bp_addr/bp_taken stable until GAP. fifo_count decrements only on training_done.
- Push 5 events back-to-back while in WAIT_MEM -> first 4 accepted, in_ready=0 on the 5th, which is dropped. Issue order matches push order. Pointer wrap verified by pushing 2 more after 2 pops.
- Predictor model never responds -> after 127 cycles timeout_err=1, no out_valid, entry popped, next entry issued.
- Assert rst_n low mid-WAIT_TRAIN with 3 queued -> all outputs at reset values asynchronously, fifo_count=0, state WAIT_MEM.
